// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, K=3 convolutional encoder (g1 = 7 octal, g0 = 5 octal).
// Serial data bits arrive over a valid/ready handshake and leave as 2-bit code
// symbols {c1,c0} through a single registered output slot. Data is framed in
// blocks of FRAME_LEN bits.
// Optional feature macro: CONV_ENC_TAIL_EN -- when defined, two zero tail bits
// are appended to every frame so the encoder returns to state 00 and sym_last
// marks the second tail symbol. When undefined, frames are truncated and
// sym_last marks the symbol of the final data bit.
module conv_encoder #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       d_valid,
  output logic       d_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_last,
  output logic [3:0] enc_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Symbol count of the last data bit and of the last tail bit in a frame.
  localparam logic [3:0] DATA_LAST = 4'(FRAME_LEN);
  localparam logic [3:0] TAIL_LAST = 4'(FRAME_LEN + 2);

  state_t     state_r;
  state_t     state_nx_s;
  logic [1:0] enc_st_r;     // {s1,s0}, s1 = most recent bit
  logic [1:0] enc_st_nx_s;
  logic [3:0] cnt_nx_s;
  logic       slot_free_s;
  logic       accept_s;
  logic       load_s;
  logic       bit_s;
  logic       last_s;
  logic [1:0] sym_s;

  // Code symbol for input bit b in encoder state {s1,s0}.
  function automatic logic [1:0] conv_sym(input logic b, input logic [1:0] st);
    return {b ^ st[1] ^ st[0], b ^ st[0]};
  endfunction

  // Handshake decode, next-state, counter and slot-load decisions.
  always_comb begin
    slot_free_s = !sym_valid || sym_ready;
    if (state_r == TAIL) begin
      d_ready = 1'b0;
    end else begin
      d_ready = rst_n & slot_free_s;
    end
    accept_s   = d_valid & d_ready;
    state_nx_s = state_r;
    cnt_nx_s   = enc_cnt;
    load_s     = 1'b0;
    bit_s      = 1'b0;
    last_s     = 1'b0;

    case (state_r)
      IDLE, DATA: begin
        if (accept_s) begin
          load_s = 1'b1;
          bit_s  = d_in;
          if (state_r == IDLE) begin
            cnt_nx_s = 4'd1;
          end else begin
            cnt_nx_s = enc_cnt + 4'd1;
          end
          if (cnt_nx_s == DATA_LAST) begin
`ifdef CONV_ENC_TAIL_EN
            state_nx_s = TAIL;
`else
            state_nx_s = IDLE;
            last_s     = 1'b1;
`endif
          end else begin
            state_nx_s = DATA;
          end
        end else begin
          // A finished frame's count is shown once, then cleared while idle.
          if (state_r == IDLE) begin
            cnt_nx_s = 4'd0;
          end else begin
            cnt_nx_s = enc_cnt;
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL: begin
        if (slot_free_s) begin
          load_s   = 1'b1;
          bit_s    = 1'b0;
          cnt_nx_s = enc_cnt + 4'd1;
          if (cnt_nx_s == TAIL_LAST) begin
            state_nx_s = IDLE;
            last_s     = 1'b1;
          end else begin
            state_nx_s = TAIL;
          end
        end else begin
          state_nx_s = TAIL;
        end
      end
`endif
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase

    // The shift register restarts from 00 whenever a frame closes.
    if (load_s) begin
      if (state_nx_s == IDLE) begin
        enc_st_nx_s = 2'b00;
      end else begin
        enc_st_nx_s = {bit_s, enc_st_r[1]};
      end
    end else begin
      enc_st_nx_s = enc_st_r;
    end

    sym_s = conv_sym(bit_s, enc_st_r);
  end

  // FSM state, encoder shift register, symbol counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      enc_st_r <= 2'b00;
      enc_cnt  <= 4'd0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      enc_st_r <= enc_st_nx_s;
      enc_cnt  <= cnt_nx_s;
      busy     <= (state_nx_s != IDLE);
    end
  end

  // Output slot: replace on load, drain on ready, otherwise hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end else if (load_s) begin
      sym_out   <= sym_s;
      sym_valid <= 1'b1;
      sym_last  <= last_s;
    end else if (sym_ready) begin
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      sym_out   <= sym_out;
      sym_valid <= sym_valid;
      sym_last  <= sym_last;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: a convolution-sum model of each frame
// feeds an expected-symbol queue that is compared against every transferred
// symbol, with directed and randomized frames and random backpressure.
module tb_conv_encoder;

  localparam int FL = 8;
`ifdef CONV_ENC_TAIL_EN
  localparam int NSYM = FL + 2;
  localparam int GAP  = 2;
`else
  localparam int NSYM = FL;
  localparam int GAP  = 0;
`endif
  localparam logic [15:0] KNOWN = 16'h000D;  // bits 1,0,1,1,0,0,0,0
  localparam logic [15:0] ONES  = 16'h00FF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_in;
  logic       d_valid;
  logic       d_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_ready = 1'b1;
  logic       sym_last;
  logic [3:0] enc_cnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int         rdy_mode   = 0;   // 0: always ready, 1: random, 2: manual
  logic       rdy_manual = 1'b1;
  logic [2:0] exp_q [$];        // {last, symbol}
  logic [3:0] cnt_log [$];
  bit         log_en  = 1'b0;
  bit         gap_en  = 1'b0;
  int         gap_cnt = 0;
  bit         stall_p = 1'b0;
  logic [2:0] held    = 3'b000;

  always #5 clk = ~clk;

  conv_encoder #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_last(sym_last), .enc_cnt(enc_cnt), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Symbol i of a frame: convolution of the zero-started bit stream with 111 / 101.
  function automatic logic [1:0] model_sym(input logic [15:0] bits, input int i);
    logic b0, b1, b2;
    b0 = 1'b0; b1 = 1'b0; b2 = 1'b0;
    if (i < FL) b0 = bits[i];
    if (i >= 1 && i - 1 < FL) b1 = bits[i-1];
    if (i >= 2 && i - 2 < FL) b2 = bits[i-2];
    return {b0 ^ b1 ^ b2, b0 ^ b2};
  endfunction

  task automatic expect_syms(input logic [15:0] bits, input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({full && (i == n - 1), model_sym(bits, i)});
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit gaps, input bit keep);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int tmo;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          d_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      d_valid = 1'b1;
      d_in    = bits[i];
      acc     = 1'b0;
      tmo     = 0;
      while (!acc && tmo < 200) begin
        @(negedge clk);
        acc = d_ready;
        @(posedge clk); #1;
        tmo++;
      end
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    end
    if (!keep) d_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] bits, input bit gaps);
    expect_syms(bits, NSYM, 1'b1);
    send_bits(bits, FL, gaps, 1'b0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sym_valid) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  // Output-ready generator, updated a little after each rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       sym_ready = 1'b1;
      1:       sym_ready = ($urandom_range(0, 3) != 0);
      default: sym_ready = rdy_manual;
    endcase
  end

  // Compare process: scoreboard on every transfer, stall stability, logs.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) check("stall_hold", 32'({sym_valid, sym_last, sym_out}), 32'({1'b1, held}));
      if (sym_valid && log_en) cnt_log.push_back(enc_cnt);
      if (gap_en && d_valid && !d_ready) gap_cnt++;
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          check("sym_extra", 32'({sym_last, sym_out}), 32'hFFFF);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          check("sym", 32'({sym_last, sym_out}), 32'(e));
        end
      end
      stall_p = sym_valid && !sym_ready;
      held    = {sym_last, sym_out};
    end
  end

  initial begin
    logic [1:0] pin_known [10];
    logic [1:0] pin_ones  [10];
    bit found;
    pin_known = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    pin_ones  = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};

    // Model pinned against hand-computed sequences.
    for (int i = 0; i < 10; i++) begin
      check("pin_known", 32'(model_sym(KNOWN, i)), 32'(pin_known[i]));
      check("pin_ones", 32'(model_sym(ONES, i)), 32'(pin_ones[i]));
    end

    // Reset state.
    rst_n = 1'b0; d_valid = 1'b0; d_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'({sym_out, sym_valid, sym_last, enc_cnt, busy, d_ready}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(d_ready), 32'd1);
    @(posedge clk); #1;

    // Known sequence, continuous ready, enc_cnt trace.
    rdy_mode = 0;
    cnt_log.delete();
    log_en = 1'b1;
    send_frame(KNOWN, 1'b0);
    wait_drain();
    log_en = 1'b0;
    check("cnt_log_len", 32'(cnt_log.size()), 32'(NSYM));
    for (int i = 0; i < cnt_log.size(); i++) check("cnt_log", 32'(cnt_log[i]), 32'(i + 1));
    check("cnt_after", 32'(enc_cnt), 32'd0);

    // All-ones frame followed by the known frame (state must restart at 00).
    send_frame(ONES, 1'b0);
    send_frame(KNOWN, 1'b0);
    wait_drain();

    // Backpressure after symbol 4 of the known sequence.
    rdy_mode = 2; rdy_manual = 1'b1;
    fork
      send_frame(KNOWN, 1'b0);
      begin
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
          @(posedge clk); #1;
          found = sym_valid && (enc_cnt == 4'd4);
        end
        check("bp_found", 32'(found), 32'd1);
        rdy_manual = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_sym", 32'({sym_valid, sym_out}), 32'({1'b1, 2'b01}));
          check("bp_dready", 32'(d_ready), 32'd0);
        end
        @(posedge clk); #1;
        rdy_manual = 1'b1;
      end
    join
    wait_drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset after 5 accepted bits, then a fresh frame.
    expect_syms(KNOWN, 5, 1'b0);
    send_bits(KNOWN, 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({sym_out, sym_valid, sym_last, enc_cnt, busy, d_ready}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(KNOWN, 1'b0);
    wait_drain();

    // Back-to-back frames with d_valid held high.
    gap_cnt = 0;
    gap_en  = 1'b1;
    expect_syms(KNOWN, NSYM, 1'b1);
    expect_syms(KNOWN, NSYM, 1'b1);
    send_bits(KNOWN, FL, 1'b0, 1'b1);
    send_bits(KNOWN, FL, 1'b0, 1'b0);
    gap_en = 1'b0;
    wait_drain();
    check("b2b_gap", 32'(gap_cnt), 32'(GAP));

    // Random frames with random input gaps and random backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      logic [15:0] rb;
      rb = 16'($urandom);
      send_frame(rb, 1'b1);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
